// File: rtl/lsu_mem_ctrl_if.sv
// Interface for the load/store unit.
// Bundles the core request side and the data memory port.
// The master modport is the LSU; the slave modport is its environment.
`ifndef REG_LEN
`define REG_LEN 32
`endif

interface lsu_mem_ctrl_if;
  // core side
  logic                req_valid;
  logic                req_we;
  logic [2:0]          req_type;
  logic [`REG_LEN-1:0] req_addr;
  logic [`REG_LEN-1:0] req_wdata;
  logic                stall;
  logic                done;
  logic                bus_err;
  // memory side
  logic                mem_req;
  logic                mem_we;
  logic [`REG_LEN-1:0] mem_addr;
  logic [3:0]          mem_be;
  logic [`REG_LEN-1:0] mem_wdata;
  logic                mem_ack;
  logic [`REG_LEN-1:0] mem_rdata;
  // towards select_rd
  logic [`REG_LEN-1:0] rdata;
  logic [2:0]          sel_type;
  logic [1:0]          sel_addr_old;

  modport master (
    input  req_valid, req_we, req_type, req_addr, req_wdata,
    output stall, done, bus_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata,
    output rdata, sel_type, sel_addr_old
  );

  modport slave (
    output req_valid, req_we, req_type, req_addr, req_wdata,
    input  stall, done, bus_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata,
    input  rdata, sel_type, sel_addr_old
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between execute stage and data memory (IDLE -> REQ -> DONE).
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/HU/W requests with bus_err.
`ifndef REG_LEN
`define REG_LEN 32
`endif

module lsu_mem_ctrl #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_ctrl_if.master    bus
);

  localparam int XLEN = `REG_LEN;

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_BU = 3'b011;
  localparam logic [2:0] T_HU = 3'b100;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [2:0]        sel_type_q, sel_type_d;
  logic [1:0]        sel_addr_old_q, sel_addr_old_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              timeout;
  logic              misaligned;

  // Byte lanes touched by an access; reserved types behave as W.
  function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] a);
    case (t)
      T_B, T_BU: byte_en = 4'b0001 << a;
      T_H, T_HU: byte_en = 4'b0011 << {a[1], 1'b0};
      default:   byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_rep(input logic [2:0] t, input logic [XLEN-1:0] d);
    case (t)
      T_B, T_BU: lane_rep = {4{d[7:0]}};
      T_H, T_HU: lane_rep = {2{d[15:0]}};
      default:   lane_rep = d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (bus.req_type)
      T_B, T_BU: misaligned = 1'b0;
      T_H, T_HU: misaligned = bus.req_addr[0];
      default:   misaligned = |bus.req_addr[1:0];
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Fires on the last allowed REQ cycle; an ack in that same cycle still wins.
  assign timeout = (ACK_TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred; combinational code uses '='.
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    sel_type_d     = sel_type_q;
    sel_addr_old_d = sel_addr_old_q;
    cnt_d          = cnt_q;
    err_d          = err_q;

    bus.stall      = 1'b0;
    bus.done       = 1'b0;
    bus.bus_err    = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_be     = 4'b0000;
    bus.mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        bus.stall = bus.req_valid;
        if (bus.req_valid) begin
          we_d           = bus.req_we;
          addr_d         = bus.req_addr;
          wdata_d        = bus.req_wdata;
          sel_type_d     = bus.req_type;
          sel_addr_old_d = bus.req_addr[1:0];
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end

      REQ: begin
        bus.stall     = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        bus.mem_be    = byte_en(sel_type_q, addr_q[1:0]);
        bus.mem_wdata = we_q ? lane_rep(sel_type_q, wdata_q) : '0;
        if (bus.mem_ack) begin
          if (!we_q) rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        bus.done    = 1'b1;
        bus.bus_err = err_q;
        cnt_d       = '0;
        err_d       = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking '<=' so all flops update together
  // from the values computed in the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      sel_type_q     <= 3'b000;
      sel_addr_old_q <= 2'b00;
      cnt_q          <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      sel_type_q     <= sel_type_d;
      sel_addr_old_q <= sel_addr_old_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.sel_type     = sel_type_q;
  assign bus.sel_addr_old = sel_addr_old_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: load/store lanes, latency, timeout, reset abort, misalignment.
`ifndef REG_LEN
`define REG_LEN 32
`endif

module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.ACK_TIMEOUT(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_type  = t;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
  endtask

  // Presents a request and advances into the first REQ cycle.
  task automatic begin_access(input logic we, input logic [2:0] t,
                              input logic [31:0] a, input logic [31:0] d);
    start_req(we, t, a, d);
    tick();
  endtask

  // Acks in the current REQ cycle and advances into the DONE cycle.
  task automatic ack_access(input logic [31:0] rd);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic end_access();
    bus.req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_type = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    tick(); tick();
    checks++;
    if ({bus.stall, bus.done, bus.bus_err, bus.mem_req, bus.mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000",
        {bus.stall, bus.done, bus.bus_err, bus.mem_req, bus.mem_we});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 68'h0) begin
      errors++; $display("FAIL reset_mem got %h exp 0", {bus.mem_addr, bus.mem_be, bus.mem_wdata});
    end
    checks++;
    if ({bus.rdata, bus.sel_type, bus.sel_addr_old} !== 37'h0) begin
      errors++; $display("FAIL reset_sel got %h exp 0", {bus.rdata, bus.sel_type, bus.sel_addr_old});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_w();
    start_req(1'b0, 3'b010, 32'h100, 32'h0);  // cycle 0
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL idle_stall got %b exp 1", bus.stall); end
    tick();                                   // cycle 1
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b10_1111) begin
      errors++; $display("FAIL lw_ctrl got %b exp 101111", {bus.mem_req, bus.mem_we, bus.mem_be});
    end
    checks++;
    if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h exp 00000100", bus.mem_addr); end
    checks++;
    if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL lw_wdata got %h exp 0", bus.mem_wdata); end
    checks++;
    if ({bus.sel_type, bus.sel_addr_old} !== 5'b010_00) begin
      errors++; $display("FAIL lw_sel got %b exp 01000", {bus.sel_type, bus.sel_addr_old});
    end
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL lw_early_done got %b exp 0", bus.done); end
    ack_access(32'h12345678);                 // cycle 4
    checks++;
    if ({bus.done, bus.bus_err, bus.stall, bus.mem_req} !== 4'b1000) begin
      errors++; $display("FAIL lw_done got %b exp 1000", {bus.done, bus.bus_err, bus.stall, bus.mem_req});
    end
    checks++;
    if (bus.rdata !== 32'h12345678) begin errors++; $display("FAIL lw_rdata got %h exp 12345678", bus.rdata); end
    end_access();
    checks++;
    if ({bus.done, bus.stall} !== 2'b00) begin errors++; $display("FAIL lw_after got %b exp 00", {bus.done, bus.stall}); end
  endtask

  task automatic test_store_b();
    begin_access(1'b1, 3'b000, 32'h203, 32'h123456AB);
    checks++;
    if ({bus.mem_we, bus.mem_be} !== 5'b1_1000) begin
      errors++; $display("FAIL sb_be got %b exp 11000", {bus.mem_we, bus.mem_be});
    end
    checks++;
    if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL sb_addr got %h exp 00000200", bus.mem_addr); end
    checks++;
    if (bus.mem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata got %h exp abababab", bus.mem_wdata); end
    ack_access(32'hDEADBEEF);
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL sb_done got %b exp 1", bus.done); end
    checks++;
    if (bus.rdata !== 32'h12345678) begin errors++; $display("FAIL sb_rdata got %h exp 12345678", bus.rdata); end
    end_access();
  endtask

  task automatic test_halfword_byte();
    begin_access(1'b1, 3'b001, 32'h42, 32'hCAFEBEEF);
    checks++;
    if (bus.mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", bus.mem_be); end
    checks++;
    if (bus.mem_wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", bus.mem_wdata); end
    ack_access(32'h0);
    end_access();

    begin_access(1'b0, 3'b100, 32'h40, 32'hFFFFFFFF);
    checks++;
    if ({bus.mem_be, bus.sel_type, bus.sel_addr_old} !== 9'b0011_100_00) begin
      errors++; $display("FAIL lhu_be_sel got %b exp 001110000", {bus.mem_be, bus.sel_type, bus.sel_addr_old});
    end
    checks++;
    if ({bus.mem_we, bus.mem_wdata} !== 33'h0) begin
      errors++; $display("FAIL lhu_wdata got %h exp 0", {bus.mem_we, bus.mem_wdata});
    end
    ack_access(32'h0000A5A5);
    checks++;
    if (bus.rdata !== 32'h0000A5A5) begin errors++; $display("FAIL lhu_rdata got %h exp 0000a5a5", bus.rdata); end
    end_access();
    checks++;
    if ({bus.sel_type, bus.sel_addr_old} !== 5'b100_00) begin
      errors++; $display("FAIL sel_hold got %b exp 10000", {bus.sel_type, bus.sel_addr_old});
    end

    begin_access(1'b0, 3'b000, 32'h201, 32'h0);
    checks++;
    if ({bus.mem_be, bus.sel_type, bus.sel_addr_old} !== 9'b0010_000_01) begin
      errors++; $display("FAIL lb_be_sel got %b exp 001000001", {bus.mem_be, bus.sel_type, bus.sel_addr_old});
    end
    ack_access(32'h00003300);
    end_access();
  endtask

  task automatic test_back_to_back();
    begin_access(1'b0, 3'b010, 32'h10, 32'h0);
    ack_access(32'h11111111);
    // new request already present during DONE; it must wait for IDLE
    start_req(1'b1, 3'b010, 32'h20, 32'h87654321);
    tick();
    checks++;
    if ({bus.mem_req, bus.stall} !== 2'b01) begin
      errors++; $display("FAIL b2b_idle got %b exp 01", {bus.mem_req, bus.stall});
    end
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h20, 32'h87654321}) begin
      errors++; $display("FAIL b2b_req got %h exp 1_00000020_87654321", {bus.mem_req, bus.mem_addr, bus.mem_wdata});
    end
    ack_access(32'h0);
    checks++;
    if (bus.rdata !== 32'h11111111) begin errors++; $display("FAIL b2b_rdata got %h exp 11111111", bus.rdata); end
    end_access();
  endtask

  task automatic test_timeout();
    int n;
    begin_access(1'b0, 3'b010, 32'h30, 32'h0);
    n = 0;
    while (bus.mem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL to_req_cycles got %0d exp 16", n); end
    checks++;
    if ({bus.done, bus.bus_err, bus.stall} !== 3'b110) begin
      errors++; $display("FAIL to_done got %b exp 110", {bus.done, bus.bus_err, bus.stall});
    end
    checks++;
    if (bus.rdata !== 32'h11111111) begin errors++; $display("FAIL to_rdata got %h exp 11111111", bus.rdata); end
    end_access();
    checks++;
    if ({bus.done, bus.bus_err, bus.stall} !== 3'b000) begin
      errors++; $display("FAIL to_after got %b exp 000", {bus.done, bus.bus_err, bus.stall});
    end
    // counter must start from zero again
    begin_access(1'b0, 3'b010, 32'h34, 32'h0);
    repeat (15) tick();
    checks++;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL to_cnt_clear got %b exp 1", bus.mem_req); end
    ack_access(32'h22222222);
    checks++;
    if ({bus.done, bus.bus_err} !== 2'b10) begin
      errors++; $display("FAIL to_late_ack got %b exp 10", {bus.done, bus.bus_err});
    end
    end_access();
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    begin_access(1'b1, 3'b010, 32'h300, 32'h11223344);
    tick();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.stall, bus.done, bus.mem_be} !== 8'h0) begin
      errors++; $display("FAIL rst_mid_ctrl got %b exp 0", {bus.mem_req, bus.mem_we, bus.stall, bus.done, bus.mem_be});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rdata, bus.sel_type} !== 99'h0) begin
      errors++; $display("FAIL rst_mid_data got %h exp 0", {bus.mem_addr, bus.mem_wdata, bus.rdata, bus.sel_type});
    end
    seen_done = 1'b0;
    repeat (2) begin tick(); if (bus.done !== 1'b0) seen_done = 1'b1; end
    rst = 1'b0;
    repeat (3) begin tick(); if (bus.done !== 1'b0) seen_done = 1'b1; end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL rst_mid_nodone got %b exp 0", seen_done); end
    begin_access(1'b0, 3'b010, 32'h8, 32'h0);
    ack_access(32'hCAFEF00D);
    checks++;
    if ({bus.done, bus.rdata} !== {1'b1, 32'hCAFEF00D}) begin
      errors++; $display("FAIL rst_mid_next got %h exp 1_cafef00d", {bus.done, bus.rdata});
    end
    end_access();
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    start_req(1'b0, 3'b010, 32'h101, 32'h0);
    tick();
    checks++;
    if ({bus.mem_req, bus.done, bus.bus_err} !== 3'b011) begin
      errors++; $display("FAIL mis_trap got %b exp 011", {bus.mem_req, bus.done, bus.bus_err});
    end
    checks++;
    if (bus.rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_rdata got %h exp cafef00d", bus.rdata); end
    end_access();
    checks++;
    if ({bus.mem_req, bus.done, bus.bus_err} !== 3'b000) begin
      errors++; $display("FAIL mis_after got %b exp 000", {bus.mem_req, bus.done, bus.bus_err});
    end
`else
    begin_access(1'b0, 3'b010, 32'h101, 32'h0);
    checks++;
    if ({bus.mem_req, bus.mem_be, bus.mem_addr} !== {1'b1, 4'b1111, 32'h100}) begin
      errors++; $display("FAIL mis_norm got %h exp 1f00000100", {bus.mem_req, bus.mem_be, bus.mem_addr});
    end
    ack_access(32'h55AA55AA);
    checks++;
    if ({bus.done, bus.bus_err, bus.rdata} !== {2'b10, 32'h55AA55AA}) begin
      errors++; $display("FAIL mis_done got %h exp 255aa55aa", {bus.done, bus.bus_err, bus.rdata});
    end
    end_access();
    begin_access(1'b0, 3'b001, 32'h41, 32'h0);
    checks++;
    if (bus.mem_be !== 4'b0011) begin errors++; $display("FAIL mis_h_be got %b exp 0011", bus.mem_be); end
    ack_access(32'h0);
    end_access();
`endif
  endtask

  initial begin
    test_reset();
    test_load_w();
    test_store_b();
    test_halfword_byte();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
